// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite bus encodings and the memory slave's FSM state type
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'd0, HTRANS_BUSY = 2'd1, HTRANS_NONSEQ = 2'd2, HTRANS_SEQ = 2'd3;
  localparam logic [2:0] HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'd0, HBURST_INCR = 3'd1, HBURST_WRAP4 = 3'd2, HBURST_INCR4 = 3'd3,
                         HBURST_WRAP8 = 3'd4, HBURST_INCR8 = 3'd5, HBURST_WRAP16 = 3'd6, HBURST_INCR16 = 3'd7;
  localparam logic HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;
endpackage

// File: rtl/ahb_byte_strobe.sv
// ahb_byte_strobe: HSIZE/address lanes to byte strobe plus illegal-size/misalignment flag
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o,
  output logic       bad_o
);
  always_comb begin
    strb_o = size_i == HSIZE_BYTE ? 4'b0001 << addr_i : size_i == HSIZE_HALF ? 4'b0011 << addr_i : 4'b1111;
    bad_o  = size_i > HSIZE_WORD || (size_i == HSIZE_HALF && addr_i[0]) || (size_i == HSIZE_WORD && addr_i != 2'd0);
  end
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite word memory slave with byte lanes, wait states and ERROR response
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_DEPTH    = 256,
  parameter int WAIT_STATES  = 0,
  parameter int HBURST_WIDTH = 3
) (
  input  logic                    HCLK,
  input  logic                    HRST,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [HBURST_WIDTH-1:0] HBURST,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic                    HREADY,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP
);
  localparam int IW = $clog2(MEM_DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  state_e state_q, state_d;
  logic ready_q, resp_q, write_q, accept, bad, unused_burst;
  logic [3:0] cnt_q, strb_q, strb_d;
  logic [IW-1:0] idx_q;
  assign unused_burst = ^HBURST;
  ahb_byte_strobe u_strb (.size_i(HSIZE), .addr_i(HADDR[1:0]), .strb_o(strb_d), .bad_o(bad));
  always_comb begin
    accept  = HSEL && HREADY && ready_q && HTRANS[1];
    state_d = !accept ? S_IDLE
            : (bad || HADDR >= ADDR_WIDTH'(4 * MEM_DEPTH)) ? S_ERR1
            : (HTRANS == HTRANS_NONSEQ && WAIT_STATES > 0) ? S_WAIT : S_DATA;
  end
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
      write_q <= 1'b0;
      cnt_q   <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
    end else begin
      if (accept) begin
        idx_q   <= HADDR[IW+1:2];
        write_q <= HWRITE;
        strb_q  <= strb_d;
        cnt_q   <= 4'(WAIT_STATES - 1);
      end else if (state_q == S_WAIT) cnt_q <= cnt_q - 4'd1;
      case (state_q)
        S_WAIT: if (cnt_q == 4'd0) begin
          state_q <= S_DATA;
          ready_q <= 1'b1;
        end
        S_ERR1: begin
          state_q <= S_ERR2;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= state_d;
          ready_q <= state_d == S_IDLE || state_d == S_DATA;
          resp_q  <= state_d == S_ERR1;
        end
      endcase
    end
  end
  // memory is deliberately not reset; a write is dropped if reset lands on its final cycle
  always_ff @(posedge HCLK) begin
    if (!HRST && state_q == S_DATA && write_q)
      for (int b = 0; b < 4; b++)
        if (strb_q[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
  end
  assign HRDATA    = (state_q == S_DATA && !write_q) ? mem_q[idx_q] : '0;
  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;
endmodule
